// File: rtl/piece_controller.sv
// Active-piece sequencer: spawns tetrominoes, probes candidate poses against the
// board's collision output, commits legal poses and strobes locks. Optional wall kick: WALL_KICK_EN.
module piece_controller #(
  parameter int          GRAVITY_TICKS = 25000000,
  parameter int          GRAV_W        = 25,
  parameter int          SPAWN_X       = 3,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        rotate,
  input  logic        soft_drop,
  input  logic        hard_drop,
  input  logic        collision,
  output logic [3:0]  piece_x,
  output logic [4:0]  piece_y,
  output logic [2:0]  piece_type,
  output logic [1:0]  piece_rotation,
  output logic        place_piece,
  output logic        game_over,
  output logic        playing,
  output logic [15:0] pieces_placed
);

  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN, S_SPAWN_CHK, S_FALL, S_CHECK, S_LOCK, S_GAME_OVER
  } state_t;

  typedef enum logic [2:0] {
    OP_GRAV, OP_SOFT, OP_HARD, OP_ROT, OP_LEFT, OP_RIGHT
  } op_t;

  state_t              state_q, state_d;
  op_t                 op_q, op_d;
  logic [3:0]          px_q, px_d, cx_q, cx_d;
  logic [4:0]          py_q, py_d, cy_q, cy_d;
  logic [1:0]          prot_q, prot_d, crot_q, crot_d;
  logic [2:0]          ptype_q, ptype_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [15:0]         placed_q, placed_d;
  logic [GRAV_W-1:0]   grav_cnt_q, grav_cnt_d;
  logic                pending_q, pending_d;
  logic                pend_set, pend_clr;
  logic [2:0]          spawn_type;
`ifdef WALL_KICK_EN
  // 0: plain rotate probed, 1: x-1 retry probed, 2: x+1 retry probed
  logic [1:0]          kick_q, kick_d;
`endif

  assign spawn_type = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];

  // State register
  always_ff @(posedge clk) begin
    // NOTE: every flop uses non-blocking assignment so all registers update from
    // the same pre-edge values, independent of statement order.
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= OP_GRAV;
      px_q       <= '0;
      py_q       <= '0;
      prot_q     <= '0;
      ptype_q    <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      crot_q     <= '0;
      lfsr_q     <= LFSR_SEED;
      placed_q   <= '0;
      grav_cnt_q <= '0;
      pending_q  <= 1'b0;
`ifdef WALL_KICK_EN
      kick_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      px_q       <= px_d;
      py_q       <= py_d;
      prot_q     <= prot_d;
      ptype_q    <= ptype_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      crot_q     <= crot_d;
      lfsr_q     <= lfsr_d;
      placed_q   <= placed_d;
      grav_cnt_q <= grav_cnt_d;
      pending_q  <= pending_d;
`ifdef WALL_KICK_EN
      kick_q     <= kick_d;
`endif
    end
  end

  // Next-state and datapath
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d    = state_q;
    op_d       = op_q;
    px_d       = px_q;
    py_d       = py_q;
    prot_d     = prot_q;
    ptype_d    = ptype_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    crot_d     = crot_q;
    placed_d   = placed_q;
    grav_cnt_d = grav_cnt_q;
    pend_set   = 1'b0;
    pend_clr   = 1'b0;
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`ifdef WALL_KICK_EN
    kick_d     = kick_q;
`endif

    if (state_q == S_FALL || state_q == S_CHECK) begin
      if (grav_cnt_q == GRAV_W'(GRAVITY_TICKS - 1)) begin
        grav_cnt_d = '0;
        pend_set   = 1'b1;
      end else begin
        grav_cnt_d = grav_cnt_q + GRAV_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          placed_d = '0;
          state_d  = S_SPAWN;
        end
      end
      S_SPAWN: begin
        px_d    = 4'(SPAWN_X);
        py_d    = '0;
        prot_d  = '0;
        ptype_d = spawn_type;
        state_d = S_SPAWN_CHK;
      end
      S_SPAWN_CHK: begin
        if (collision) begin
          state_d = S_GAME_OVER;
        end else begin
          cx_d       = px_q;
          cy_d       = py_q;
          crot_d     = prot_q;
          grav_cnt_d = '0;
          state_d    = S_FALL;
        end
      end
      S_FALL: begin
        if (hard_drop) begin
          py_d = cy_q + 5'd1; op_d = OP_HARD; state_d = S_CHECK;
        end else if (rotate) begin
          prot_d = crot_q + 2'd1; op_d = OP_ROT; state_d = S_CHECK;
`ifdef WALL_KICK_EN
          kick_d = '0;
`endif
        end else if (move_left) begin
          // Left at column 0 is consumed without a probe
          if (cx_q != '0) begin
            px_d = cx_q - 4'd1; op_d = OP_LEFT; state_d = S_CHECK;
          end
        end else if (move_right) begin
          px_d = cx_q + 4'd1; op_d = OP_RIGHT; state_d = S_CHECK;
        end else if (soft_drop) begin
          py_d = cy_q + 5'd1; op_d = OP_SOFT; state_d = S_CHECK;
        end else if (pending_q) begin
          py_d = cy_q + 5'd1; op_d = OP_GRAV; state_d = S_CHECK; pend_clr = 1'b1;
        end
      end
      S_CHECK: begin
        if (!collision) begin
          cx_d   = px_q;
          cy_d   = py_q;
          crot_d = prot_q;
          if (op_q == OP_HARD) py_d = py_q + 5'd1;
          else                 state_d = S_FALL;
        end else begin
          px_d   = cx_q;
          py_d   = cy_q;
          prot_d = crot_q;
          case (op_q)
            OP_GRAV, OP_SOFT, OP_HARD: state_d = S_LOCK;
`ifdef WALL_KICK_EN
            OP_ROT: begin
              if (kick_q == 2'd0 && cx_q != '0) begin
                px_d = cx_q - 4'd1; prot_d = prot_q; kick_d = 2'd1;
              end else if (kick_q != 2'd2) begin
                px_d = cx_q + 4'd1; prot_d = prot_q; kick_d = 2'd2;
              end else begin
                state_d = S_FALL;
              end
            end
`endif
            default: state_d = S_FALL;
          endcase
        end
      end
      S_LOCK: begin
        px_d     = cx_q;
        py_d     = cy_q;
        prot_d   = crot_q;
        placed_d = placed_q + 16'd1;
        pend_clr = 1'b1;
        state_d  = S_SPAWN;
      end
      S_GAME_OVER: begin
        if (start) begin
          cx_d     = '0;
          cy_d     = '0;
          crot_d   = '0;
          placed_d = '0;
          state_d  = S_SPAWN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    pending_d = pending_q;
    if (pend_clr) pending_d = 1'b0;
    if (pend_set) pending_d = 1'b1;
  end

  // Outputs
  always_comb begin
    piece_x        = px_q;
    piece_y        = py_q;
    piece_type     = ptype_q;
    piece_rotation = prot_q;
    pieces_placed  = placed_q;
    place_piece    = (state_q == S_LOCK);
    game_over      = (state_q == S_GAME_OVER);
    playing        = (state_q != S_IDLE) && (state_q != S_GAME_OVER);
  end

endmodule

// File: tb/tb_piece_controller.sv
// Bench for piece_controller: directed scenarios plus random moves checked against
// a transaction-level model of the board rules (legal-pose function, committed pose).
module tb_piece_controller;
  localparam int GT = 8;
`ifdef WALL_KICK_EN
  localparam bit KICK = 1'b1;
`else
  localparam bit KICK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, move_left, move_right, rotate, soft_drop, hard_drop;
  logic        collision;
  logic [3:0]  piece_x;
  logic [4:0]  piece_y;
  logic [2:0]  piece_type;
  logic [1:0]  piece_rotation;
  logic        place_piece, game_over, playing;
  logic [15:0] pieces_placed;

  int checks = 0;
  int failures = 0;
  int place_cnt = 0;

  // Board model: right wall, floor, a notch for rotation 3, and a kick obstacle
  int floor_y = 20;
  bit force_coll = 1'b0;
  bit kick_on = 1'b0;
  int kick_r = 0;
  int kick_x = 0;
  int mx, my, mr;
  logic [15:0] ref_lfsr;

  piece_controller #(.GRAVITY_TICKS(GT), .GRAV_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .move_left(move_left),
    .move_right(move_right), .rotate(rotate), .soft_drop(soft_drop),
    .hard_drop(hard_drop), .collision(collision), .piece_x(piece_x),
    .piece_y(piece_y), .piece_type(piece_type), .piece_rotation(piece_rotation),
    .place_piece(place_piece), .game_over(game_over), .playing(playing),
    .pieces_placed(pieces_placed)
  );

  always #5 clk = ~clk;

  always_comb
    collision = force_coll || (int'(piece_x) > 9) || (int'(piece_y) > floor_y) ||
                (int'(piece_rotation) == 3 && int'(piece_x) >= 7) ||
                (kick_on && int'(piece_rotation) == kick_r && int'(piece_x) <= kick_x);

  always @(posedge clk)
    ref_lfsr <= rst ? 16'hACE1
                    : {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};

  always @(negedge clk)
    if (place_piece === 1'b1) place_cnt <= place_cnt + 1;

  function automatic bit hit(input int x, input int y, input int r);
    return (x > 9) || (y > floor_y) || (r == 3 && x >= 7) ||
           (kick_on && r == kick_r && x <= kick_x);
  endfunction

  function automatic int spawn_type(input logic [15:0] l);
    return (l[2:0] == 3'd7) ? 0 : int'(l[2:0]);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called during the SPAWN cycle; ends in FALL with the model at the spawn pose
  task automatic expect_spawn;
    int et;
    et = spawn_type(ref_lfsr);
    tick;
    check("spawn_x", 32'(piece_x), 3);
    check("spawn_y", 32'(piece_y), 0);
    check("spawn_rot", 32'(piece_rotation), 0);
    check("spawn_type", 32'(piece_type), et);
    tick;
    mx = 3; my = 0; mr = 0;
  endtask

  task automatic wait_place(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick;
      if (place_piece === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("place_seen", 32'(seen), 1);
  endtask

  // One request from FALL: 0 left, 1 right, 2 rotate, 3 soft drop
  task automatic do_req(input int op);
    int cyc, ex, ey, er;
    int cand[$];
    ex = mx; ey = my; er = mr; cyc = 1;
    case (op)
      0: if (mx == 0) cyc = 0; else if (!hit(mx - 1, my, mr)) ex = mx - 1;
      1: if (!hit(mx + 1, my, mr)) ex = mx + 1;
      3: if (!hit(mx, my + 1, mr)) ey = my + 1;
      default: begin
        cand = {mx};
        if (KICK) begin
          if (mx != 0) cand.push_back(mx - 1);
          cand.push_back(mx + 1);
        end
        for (int i = 0; i < cand.size(); i++) begin
          cyc = i + 1;
          if (!hit(cand[i], my, (mr + 1) % 4)) begin
            ex = cand[i];
            er = (mr + 1) % 4;
            break;
          end
        end
      end
    endcase
    move_left = (op == 0); move_right = (op == 1);
    rotate = (op == 2); soft_drop = (op == 3);
    tick;
    move_left = 0; move_right = 0; rotate = 0; soft_drop = 0;
    repeat (cyc) tick;
    mx = ex; my = ey; mr = er;
    check("req_x", 32'(piece_x), mx);
    check("req_y", 32'(piece_y), my);
    check("req_rot", 32'(piece_rotation), mr);
  endtask

  initial begin
    int y_prev, t_prev, nchg, lock_y, r0, op;
    rst = 1; start = 0; move_left = 0; move_right = 0;
    rotate = 0; soft_drop = 0; hard_drop = 0;
    tick; tick;
    check("rst_x", 32'(piece_x), 0);
    check("rst_y", 32'(piece_y), 0);
    check("rst_type", 32'(piece_type), 0);
    check("rst_rot", 32'(piece_rotation), 0);
    check("rst_place", 32'(place_piece), 0);
    check("rst_gameover", 32'(game_over), 0);
    check("rst_playing", 32'(playing), 0);
    check("rst_placed", 32'(pieces_placed), 0);
    rst = 0;
    tick;
    check("idle_playing", 32'(playing), 0);
    start = 1; tick; start = 0;
    check("spawn_playing", 32'(playing), 1);
    expect_spawn;

    // Walk to column 0, rejected left, then a right step
    repeat (3) do_req(0);
    check("left_edge_x", 32'(piece_x), 0);
    do_req(0);
    do_req(1);
    check("right_x", 32'(piece_x), 1);

    // Gravity: steady-state period between drops
    y_prev = int'(piece_y); t_prev = -1; nchg = 0;
    for (int i = 0; i < 60 && nchg < 4; i++) begin
      tick;
      if (int'(piece_y) != y_prev) begin
        check("grav_step", 32'(piece_y), y_prev + 1);
        if (nchg >= 2) check("grav_period", i - t_prev, GT);
        t_prev = i; y_prev = int'(piece_y); nchg++;
      end
    end
    check("grav_changes", nchg, 4);
    check("no_place_yet", place_cnt, 0);

    // Gravity probe blocked -> lock at the committed row
    tick;
    lock_y = int'(piece_y);
    floor_y = lock_y;
    wait_place(20);
    check("grav_lock_y", 32'(piece_y), lock_y);
    tick;
    floor_y = 20;
    check("place_one_cycle", 32'(place_piece), 0);
    check("placed_1", 32'(pieces_placed), 1);
    check("place_cnt_1", place_cnt, 1);
    expect_spawn;

    // Hard drop blocked at row 6 -> locks at row 5
    floor_y = 5;
    hard_drop = 1; tick; hard_drop = 0;
    wait_place(20);
    check("hard_y", 32'(piece_y), 5);
    check("hard_x", 32'(piece_x), 3);
    tick;
    floor_y = 20;
    check("placed_2", 32'(pieces_placed), 2);
    check("place_cnt_2", place_cnt, 2);
    expect_spawn;

    // Random back-to-back moves (requests outrank pending gravity)
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 3);
      if (op == 3 && hit(mx, my + 1, mr)) op = 1;
      do_req(op);
    end

    // Blocked rotate at column 4
    for (int n = 0; n < 20 && mx != 4; n++) do_req(mx < 4 ? 1 : 0);
    check("kick_setup_x", 32'(piece_x), 4);
    r0 = mr;
    kick_on = 1; kick_r = (mr + 1) % 4; kick_x = 4;
    do_req(2);
    check("kick_x", 32'(piece_x), KICK ? 5 : 4);
    check("kick_rot", 32'(piece_rotation), KICK ? (r0 + 1) % 4 : r0);
    kick_on = 0;

    // Lock then spawn into a collision -> game over
    hard_drop = 1; tick; hard_drop = 0;
    wait_place(40);
    check("floor_y", 32'(piece_y), 20);
    force_coll = 1;
    tick; tick; tick;
    check("go_flag", 32'(game_over), 1);
    check("go_playing", 32'(playing), 0);
    check("go_x", 32'(piece_x), 3);
    check("go_y", 32'(piece_y), 0);
    check("go_placed", 32'(pieces_placed), 3);
    check("go_place_cnt", place_cnt, 3);
    force_coll = 0;
    repeat (3) tick;
    check("go_hold", 32'(game_over), 1);
    start = 1; tick; start = 0;
    check("restart_placed", 32'(pieces_placed), 0);
    check("restart_gameover", 32'(game_over), 0);
    check("restart_playing", 32'(playing), 1);
    expect_spawn;

    // Reset in the middle of a hard drop aborts without a lock
    hard_drop = 1; tick; hard_drop = 0;
    rst = 1; tick; tick; rst = 0;
    repeat (3) tick;
    check("abort_x", 32'(piece_x), 0);
    check("abort_y", 32'(piece_y), 0);
    check("abort_playing", 32'(playing), 0);
    check("abort_place_cnt", place_cnt, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
